// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: round-robin grant, optional master-1 burst lock bounded by
// MAX_BURST, and one-cycle read-data return routed to the master that issued the read.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_we,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_we,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  input  logic              m1_lock,
  output logic              s_en,
  output logic [ADDR_W-1:0] s_addr,
  output logic [3:0]        s_we,
  output logic [31:0]       s_wdata,
  input  logic [31:0]       s_rdata
);

  typedef enum logic [0:0] {StArb, StLock1} state_e;

  localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

  state_e      state_q, state_d;
  logic        last_owner_q, last_owner_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic        rd_pend_q, rd_pend_d;
  logic        rd_tag_q, rd_tag_d;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    // Grants are gated by rstn so nothing reaches the slave while reset is held.
    if (rstn) begin
      unique case (state_q)
        StArb: begin
          if (m0_req && (!m1_req || last_owner_q)) begin
            m0_gnt = 1'b1;
          end else if (m1_req) begin
            m1_gnt = 1'b1;
          end
          if (m1_gnt && m1_lock) begin
            state_d     = StLock1;
            burst_cnt_d = 8'd1;
          end
        end
        StLock1: begin
          if (!m1_req || !m1_lock) begin
            m1_gnt      = m1_req;
            state_d     = StArb;
            burst_cnt_d = 8'd0;
          end else if (burst_cnt_q == MaxBurst && m0_req) begin
            // Forced release: idle one cycle; last_owner is already 1 so m0 wins next.
            state_d     = StArb;
            burst_cnt_d = 8'd0;
          end else begin
            m1_gnt = 1'b1;
            if (burst_cnt_q != MaxBurst) begin
              burst_cnt_d = burst_cnt_q + 8'd1;
            end
          end
        end
        default: state_d = StArb;
      endcase
    end
    if (m0_gnt) begin
      last_owner_d = 1'b0;
    end else if (m1_gnt) begin
      last_owner_d = 1'b1;
    end
  end

  always_comb begin
    s_en    = m0_gnt | m1_gnt;
    s_addr  = '0;
    s_we    = 4'b0000;
    s_wdata = 32'd0;
    if (m0_gnt) begin
      s_addr  = m0_addr;
      s_we    = m0_we;
      s_wdata = m0_wdata;
    end else if (m1_gnt) begin
      s_addr  = m1_addr;
      s_we    = m1_we;
      s_wdata = m1_wdata;
    end
    rd_pend_d = s_en && (s_we == 4'b0000);
    rd_tag_d  = m1_gnt;
  end

  always_comb begin
    m0_rvalid = rd_pend_q && !rd_tag_q;
    m1_rvalid = rd_pend_q && rd_tag_q;
    m0_rdata  = m0_rvalid ? s_rdata : 32'd0;
    m1_rdata  = m1_rvalid ? s_rdata : 32'd0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StArb;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= 8'd0;
      rd_pend_q    <= 1'b0;
      rd_tag_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_tag_q     <= rd_tag_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected grants and read returns into
// queues; a negedge monitor pops and compares whenever the DUT shows a grant or rvalid.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_req, m1_req, m1_lock;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_we, m1_we;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_en;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_we;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wd;
  } gexp_t;

  typedef struct packed {
    logic        v0;
    logic        v1;
    logic [31:0] d0;
    logic [31:0] d1;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .MAX_BURST(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_we     (m0_we),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_we     (m1_we),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .m1_lock   (m1_lock),
    .s_en      (s_en),
    .s_addr    (s_addr),
    .s_we      (s_we),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata)
  );

  always @(negedge clk) begin
    gexp_t eg, ag;
    rexp_t er, ar;
    ag = '{g0: m0_gnt, g1: m1_gnt, addr: s_addr, we: s_we, wd: s_wdata};
    ar = '{v0: m0_rvalid, v1: m1_rvalid, d0: m0_rdata, d1: m1_rdata};
    if (m0_gnt || m1_gnt) begin
      n_cmp++;
      if (!s_en) begin
        n_bad++;
        $display("FAIL s_en_low t=%0t actual s_en=%b required 1", $time, s_en);
      end else if (gq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_gnt t=%0t actual %h required no grant", $time, ag);
      end else begin
        eg = gq.pop_front();
        if (ag !== eg) begin
          n_bad++;
          $display("FAIL grant t=%0t actual %h required %h", $time, ag, eg);
        end
      end
    end else begin
      n_cmp++;
      if ({s_en, s_we, s_addr, s_wdata} !== '0) begin
        n_bad++;
        $display("FAIL idle_bus t=%0t actual en=%b we=%h addr=%h wd=%h required all 0",
                 $time, s_en, s_we, s_addr, s_wdata);
      end
    end
    if (m0_rvalid || m1_rvalid) begin
      n_cmp++;
      if (rq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rvalid t=%0t actual %h required none", $time, ar);
      end else begin
        er = rq.pop_front();
        if (ar !== er) begin
          n_bad++;
          $display("FAIL rdata t=%0t actual %h required %h", $time, ar, er);
        end
      end
    end else if ((m0_rdata | m1_rdata) !== 32'd0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_rdata t=%0t actual %h/%h required 0/0", $time, m0_rdata, m1_rdata);
    end
  end

  task automatic exp_g(input int who, input logic [31:0] a, input logic [3:0] w,
                       input logic [31:0] d);
    gq.push_back('{g0: (who == 0), g1: (who == 1), addr: a, we: w, wd: d});
  endtask

  task automatic exp_r(input int who, input logic [31:0] d);
    rq.push_back('{v0: (who == 0), v1: (who == 1),
                   d0: (who == 0) ? d : 32'd0, d1: (who == 1) ? d : 32'd0});
  endtask

  task automatic drive(input logic r0, input logic [31:0] a0, input logic [3:0] w0,
                       input logic [31:0] d0, input logic r1, input logic [31:0] a1,
                       input logic [3:0] w1, input logic [31:0] d1, input logic lk);
    @(posedge clk);
    #1;
    m0_req = r0; m0_addr = a0; m0_we = w0; m0_wdata = d0;
    m1_req = r1; m1_addr = a1; m1_we = w1; m1_wdata = d1;
    m1_lock = lk;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    chk("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("rst_s_en", {31'd0, s_en}, 32'd0);
    chk("rst_s_we", {28'd0, s_we}, 32'd0);
    chk("rst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
  endtask

  initial begin
    int b;
    logic [31:0] a0, d0;
    rstn = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h10; m0_we = 4'd0; m0_wdata = 32'd0;
    m1_req = 1'b1; m1_addr = 32'h20; m1_we = 4'd0; m1_wdata = 32'd0;
    m1_lock = 1'b0;
    s_rdata = 32'hA5A5_0001;
    repeat (2) begin
      @(negedge clk);
      chk_reset_outputs();
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;

    // Both read after reset: m0 first, m1 next, each read returned one cycle later.
    exp_g(0, 32'h10, 4'd0, 32'd0);
    exp_r(0, 32'hA5A5_0001);
    drive(1'b1, 32'h10, 4'd0, 32'd0, 1'b1, 32'h20, 4'd0, 32'd0, 1'b0);
    exp_g(1, 32'h20, 4'd0, 32'd0);
    exp_r(1, 32'hA5A5_0001);
    drive(1'b0, 32'h0, 4'd0, 32'd0, 1'b1, 32'h20, 4'd0, 32'd0, 1'b0);
    idle();

    // m0 held high, m1 pulsed on odd cycles: grants alternate m0, m1.
    for (int i = 0; i < 6; i++) begin
      a0 = 32'h100 + 32'(4 * ((i + 1) / 2));
      d0 = 32'((i + 1) / 2);
      if (i % 2 == 0) begin
        exp_g(0, a0, 4'hF, d0);
        drive(1'b1, a0, 4'hF, d0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0);
      end else begin
        exp_g(1, 32'h200 + 32'(4 * i), 4'hF, 32'h1000 + 32'(i));
        drive(1'b1, a0, 4'hF, d0, 1'b1, 32'h200 + 32'(4 * i), 4'hF, 32'h1000 + 32'(i), 1'b0);
      end
    end

    // Burst lock under m0 contention: 8 m1 beats, idle release cycle, m0, then m1 again.
    exp_g(0, 32'h300, 4'hF, 32'h55);
    drive(1'b1, 32'h300, 4'hF, 32'h55, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0);
    b = 0;
    for (int j = 1; j <= 12; j++) begin
      a0 = (j <= 10) ? 32'h304 : 32'h308;
      d0 = (j <= 10) ? 32'h66 : 32'h77;
      if (j == 10) exp_g(0, a0, 4'hF, d0);
      else if (j != 9) exp_g(1, 32'h500 + 32'(4 * b), 4'hF, 32'(b));
      drive(1'b1, a0, 4'hF, d0, 1'b1, 32'h500 + 32'(4 * b), 4'hF, 32'(b), 1'b1);
      if (j != 9 && j != 10) b++;
    end
    idle();

    // GPIO write from m1: routed to slave, no read return.
    exp_g(1, 32'h400, 4'b0001, 32'h3C);
    drive(1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 32'h400, 4'b0001, 32'h3C, 1'b0);
    idle();

    // m1 read, then reset the next cycle: the return is squashed.
    exp_g(1, 32'h30, 4'd0, 32'd0);
    drive(1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 32'h30, 4'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    m0_req = 1'b1;
    m1_req = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_reset_outputs();
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;

    // Uncontended lock for 20 beats; counter saturated at 8 forces release once m0 asks.
    for (int j = 1; j <= 20; j++) begin
      exp_g(1, 32'h600 + 32'(4 * j), 4'hF, 32'(j));
      drive(1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 32'h600 + 32'(4 * j), 4'hF, 32'(j), 1'b1);
    end
    drive(1'b1, 32'h700, 4'hF, 32'h88, 1'b1, 32'h654, 4'hF, 32'd21, 1'b1);
    exp_g(0, 32'h700, 4'hF, 32'h88);
    drive(1'b1, 32'h700, 4'hF, 32'h88, 1'b1, 32'h654, 4'hF, 32'd21, 1'b1);
    exp_g(1, 32'h654, 4'hF, 32'd21);
    drive(1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 32'h654, 4'hF, 32'd21, 1'b1);
    repeat (3) idle();
    @(negedge clk);
    chk("grants_outstanding", 32'(gq.size()), 32'd0);
    chk("reads_outstanding", 32'(rq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
